dekatron_carry_tracker: RTL and testbench
=========================================

// Module: dekatron_carry_tracker
// PURPOSE
// Clocked, multi-digit carry/borrow detector for chains of dekatron counters.
// Samples the one-hot cathode image of DIGITS dekatrons, each with POSITIONS positions.
// Each digit's image is glitch-filtered before it is accepted.
// Produces per-digit held zone flags (CarryLow/CarryHigh) and single-cycle wrap pulses
// (HIGH->LOW = carry, LOW->HIGH = borrow) for the next digit's step logic.
// PARAMETERS
// DIGITS     4   number of independent dekatron channels (>=1)
// POSITIONS  10  cathode positions per dekatron (>=3); position 0 = LOW, POSITIONS-1 = HIGH
// FILTER     2   extra consecutive identical samples required before acceptance (0..15)
// PORTS
// Clk          in   1                 system clock, rising edge
// Rst          in   1                 synchronous reset, active-high
// In           in   DIGITS*POSITIONS  one-hot cathode images; digit d = In[d*POSITIONS +: POSITIONS]
// CarryLow     out  DIGITS            digit last accepted at position 0
// CarryHigh    out  DIGITS            digit last accepted at position POSITIONS-1
// CarryPulse   out  DIGITS            1-cycle pulse on accepted HIGH->LOW wrap (count up)
// BorrowPulse  out  DIGITS            1-cycle pulse on accepted LOW->HIGH wrap (count down)
// Err          out  DIGITS            only with DEKATRON_CARRY_ERR_EN; sticky multi-hot flag
// BEHAVIOUR
// - Clock and reset: single clock domain. Reset is synchronous and active-high.
// - Reset state: all outputs 0; per-digit zone = UNK; sample regs 0; stability counters 0.
// - Reset asserted mid-operation: reset applies on the next edge. Any pending pulse is dropped.
// - Channels: all digits are fully independent. Events on several digits in the same cycle
//   are all reported in that cycle.
// - Per-digit sampling: the slice is registered every edge into smp.
//   - cnt clears to 0 when smp changes.
//   - Otherwise cnt increments, saturating at FILTER.
// - Acceptance: smp is accepted when cnt==FILTER and smp is exactly one-hot.
//   - Acceptance is repeated every cycle while stable; repeats are idempotent.
// - Latency: a one-hot value applied before edge k and held updates outputs at edge
//   k+FILTER+1. With FILTER=0, outputs update at edge k+1.
// - Zero-hot input (glow between cathodes) or multi-hot input is never accepted.
//   Zone and flags hold their last value (latch-equivalent hold).
// - Zone FSM: UNK, LOW (pos 0), MID (1..POSITIONS-2), HIGH (POSITIONS-1).
//   - Every accepted value moves the zone to the zone of that position.
//   - UNK is left only by acceptance.
// - CarryLow = (zone==LOW); CarryHigh = (zone==HIGH). Both are registered.
// - Pulse rules:
//   - CarryPulse: asserted for exactly one cycle on the edge where zone goes HIGH->LOW.
//   - BorrowPulse: asserted for exactly one cycle on the edge where zone goes LOW->HIGH.
//   - No pulse for any transition out of UNK, any transition through MID, or LOW->LOW.
//   - No pulse when the same zone is re-accepted.
// - Glitch shorter than FILTER+1 samples (including a single-sample alien position):
//   no zone change and no pulse.
// CONFIGURATION
// - DEKATRON_CARRY_ERR_EN defined:
//   - The Err port exists.
//   - Err[d] sets when smp has >=2 bits set for FILTER+1 consecutive samples.
//   - Err[d] clears only on Rst.
//   - Zone behaviour is unchanged.
// - DEKATRON_CARRY_ERR_EN undefined:
//   - No Err port and no error logic.
//   - Multi-hot input is silently held, exactly as for zero-hot.
// TESTING
// 1. Rst=1 for 2 clks with random In -> all outputs 0; then In d0=pos0 held
//    -> CarryLow[0]=1 at edge FILTER+1, no pulses.
// 2. d0 pos9 held, then pos0 held (FILTER=2) -> CarryPulse[0]=1 for exactly 1 clk,
//    3 edges after the change; CarryLow[0]=1, CarryHigh[0]=0.
// 3. d1 pos0 then pos9 -> BorrowPulse[1] for 1 clk; d1 pos0 -> pos5 -> pos9 -> no pulse;
//    CarryHigh[1]=1 at end.
// 4. d2 at pos9; 2-cycle glitch to pos0 (FILTER=2), then back to pos9 -> no pulse,
//    CarryHigh[2] stays 1; zero-hot for 20 clks -> flags held.
// 5. d0 HIGH->LOW and d3 LOW->HIGH in the same cycle -> CarryPulse[0] and BorrowPulse[3]
//    both asserted on the same edge; Rst asserted on that edge -> both pulses 0.
// 6. ERR_EN: d1 = 10'b0000010001 held 3 samples -> Err[1]=1, stays 1 after valid input;
//    Rst -> Err[1]=0.

Source files
------------

// File: rtl/dekatron_carry_tracker_if.sv
// Bundle for dekatron_carry_tracker: packed cathode images in, per-digit
// zone flags and wrap pulses out.
// The Err vector exists only when DEKATRON_CARRY_ERR_EN is defined.
interface dekatron_carry_tracker_if #(
  parameter int DIGITS    = 4,
  parameter int POSITIONS = 10
);
  logic [DIGITS*POSITIONS-1:0] In;
  logic [DIGITS-1:0]           CarryLow;
  logic [DIGITS-1:0]           CarryHigh;
  logic [DIGITS-1:0]           CarryPulse;
  logic [DIGITS-1:0]           BorrowPulse;
`ifdef DEKATRON_CARRY_ERR_EN
  logic [DIGITS-1:0]           Err;

  modport master (output In, input CarryLow, input CarryHigh,
                  input CarryPulse, input BorrowPulse, input Err);
  modport slave  (input In, output CarryLow, output CarryHigh,
                  output CarryPulse, output BorrowPulse, output Err);
`else
  modport master (output In, input CarryLow, input CarryHigh,
                  input CarryPulse, input BorrowPulse);
  modport slave  (input In, output CarryLow, output CarryHigh,
                  output CarryPulse, output BorrowPulse);
`endif
endinterface

// File: rtl/dekatron_carry_tracker.sv
// dekatron_carry_tracker: per-digit glitch filter and zone tracker for
// chained dekatron counters.
// - Each digit's cathode image is registered every edge.
// - An image is accepted once it has been identical for FILTER+1 samples
//   and is exactly one-hot.
// - The accepted position sets the zone: LOW (0), MID, or HIGH (POSITIONS-1).
// - HIGH->LOW raises a one-cycle CarryPulse; LOW->HIGH raises a one-cycle
//   BorrowPulse.
// - A one-hot value held from before edge k updates the outputs at edge
//   k+FILTER+1.
// Optional feature, enabled by the macro DEKATRON_CARRY_ERR_EN: a sticky
// per-digit Err flag that sets on a multi-hot image held stable for
// FILTER+1 samples.
module dekatron_carry_tracker #(
  parameter int DIGITS    = 4,
  parameter int POSITIONS = 10,
  parameter int FILTER    = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  dekatron_carry_tracker_if.slave  bus
);

  localparam logic [3:0] FILT = 4'(FILTER);

  typedef enum logic [1:0] {Z_UNK, Z_LOW, Z_MID, Z_HIGH} zone_t;

  logic [POSITIONS-1:0] smp_p0 [DIGITS];
  logic [3:0]           cnt_p0 [DIGITS];
  logic [DIGITS-1:0]    stable_p0;

  zone_t                zone_q [DIGITS];
  zone_t                zone_d [DIGITS];
  logic [DIGITS-1:0]    carry_d, borrow_d;
  logic [DIGITS-1:0]    carry_p1, borrow_p1;

  // Stage p0: sample each digit and count consecutive identical samples
  always_ff @(posedge Clk) begin
    for (int d = 0; d < DIGITS; d++) begin
      if (Rst) begin
        smp_p0[d] <= '0;
        cnt_p0[d] <= '0;
      end else begin
        smp_p0[d] <= bus.In[d*POSITIONS +: POSITIONS];
        if (bus.In[d*POSITIONS +: POSITIONS] != smp_p0[d])
          cnt_p0[d] <= '0;
        else if (cnt_p0[d] != FILT)
          cnt_p0[d] <= cnt_p0[d] + 4'd1;
      end
    end
  end

  // Flag each digit whose current sample has been stable for FILTER+1 samples
  always_comb begin
    stable_p0 = '0;
    for (int d = 0; d < DIGITS; d++)
      stable_p0[d] = (cnt_p0[d] == FILT);
  end

  // Next zone and wrap-pulse decode from the accepted position
  always_comb begin
    zone_t nz;
    carry_d  = '0;
    borrow_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      zone_d[d] = zone_q[d];
      nz        = Z_MID;
      if (smp_p0[d][0])
        nz = Z_LOW;
      else if (smp_p0[d][POSITIONS-1])
        nz = Z_HIGH;
      if (stable_p0[d] && $onehot(smp_p0[d])) begin
        zone_d[d]   = nz;
        carry_d[d]  = (zone_q[d] == Z_HIGH) && (nz == Z_LOW);
        borrow_d[d] = (zone_q[d] == Z_LOW)  && (nz == Z_HIGH);
      end
    end
  end

  // Stage p1: zone state register and registered wrap pulses
  always_ff @(posedge Clk) begin
    for (int d = 0; d < DIGITS; d++) begin
      if (Rst) zone_q[d] <= Z_UNK;
      else     zone_q[d] <= zone_d[d];
    end
    if (Rst) begin
      carry_p1  <= '0;
      borrow_p1 <= '0;
    end else begin
      carry_p1  <= carry_d;
      borrow_p1 <= borrow_d;
    end
  end

  // Zone flags decoded straight from the registered zone
  always_comb begin
    bus.CarryLow  = '0;
    bus.CarryHigh = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bus.CarryLow[d]  = (zone_q[d] == Z_LOW);
      bus.CarryHigh[d] = (zone_q[d] == Z_HIGH);
    end
  end

  assign bus.CarryPulse  = carry_p1;
  assign bus.BorrowPulse = borrow_p1;

`ifdef DEKATRON_CARRY_ERR_EN
  logic [DIGITS-1:0] err_q;

  // Sticky multi-hot error: set on a stable image with two or more bits lit
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_q <= '0;
    end else begin
      for (int d = 0; d < DIGITS; d++)
        if (stable_p0[d] && !$onehot0(smp_p0[d]))
          err_q[d] <= 1'b1;
    end
  end

  assign bus.Err = err_q;
`endif

endmodule

// File: tb/tb_dekatron_carry_tracker.sv
// Randomized scoreboard bench for dekatron_carry_tracker.
// - The reference model keeps, per digit, the samples seen since the last
//   reset.
// - A value counts as accepted when the last FILTER+1 samples are equal and
//   one-hot.
// - Each drive pushes the expected post-edge outputs into a queue.
// - A monitor pops one entry per edge and compares it with the DUT outputs.
module tb_dekatron_carry_tracker;
  localparam int D = 4;
  localparam int P = 10;
  localparam int F = 2;
  localparam int W = D*P;

  typedef struct {
    logic [D-1:0] lo, hi, cp, bp, er;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  exp_t q[$];

  int               zone_m [D];   // 0 unknown, 1 low, 2 mid, 3 high
  logic [P-1:0]     hist   [D][$];
  logic [D-1:0]     err_m = '0;
  logic [W-1:0]     cur   = '0;

  dekatron_carry_tracker_if #(.DIGITS(D), .POSITIONS(P)) bus();

  dekatron_carry_tracker #(.DIGITS(D), .POSITIONS(P), .FILTER(F)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [D-1:0] act, input logic [D-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, req);
    end
  endtask

  // Monitor: one expected entry per edge, compared just after that edge
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("carry_low",    bus.CarryLow,    e.lo);
        check("carry_high",   bus.CarryHigh,   e.hi);
        check("carry_pulse",  bus.CarryPulse,  e.cp);
        check("borrow_pulse", bus.BorrowPulse, e.bp);
`ifdef DEKATRON_CARRY_ERR_EN
        check("err",          bus.Err,         e.er);
`endif
      end
    end
  end

  // Drive one cycle of stimulus and predict the outputs after the next edge
  task automatic step(input logic [W-1:0] v, input logic r);
    exp_t         e;
    logic [P-1:0] last;
    bit           same;
    int           n, nz;
    Rst    = r;
    bus.In = v;
    e.cp = '0;
    e.bp = '0;
    for (int d = 0; d < D; d++) begin
      if (r) begin
        zone_m[d] = 0;
        hist[d].delete();
        err_m[d]  = 1'b0;
      end else begin
        n    = hist[d].size();
        same = (n >= F+1);
        if (same) begin
          last = hist[d][n-1];
          for (int i = 0; i <= F; i++)
            if (hist[d][n-1-i] != last) same = 0;
          if ($countones(last) == 1) begin
            nz = last[0] ? 1 : (last[P-1] ? 3 : 2);
            e.cp[d] = (zone_m[d] == 3) && (nz == 1);
            e.bp[d] = (zone_m[d] == 1) && (nz == 3);
            if (same) zone_m[d] = nz;
            if (!same) begin e.cp[d] = 1'b0; e.bp[d] = 1'b0; end
          end else if (same && $countones(last) >= 2) begin
            err_m[d] = 1'b1;
          end
        end
        hist[d].push_back(v[d*P +: P]);
        if (hist[d].size() > F+1) void'(hist[d].pop_front());
      end
      e.lo[d] = (zone_m[d] == 1);
      e.hi[d] = (zone_m[d] == 3);
    end
    e.er = err_m;
    q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic set_pos(input int d, input int p);
    logic [P-1:0] s;
    s = '0;
    s[p] = 1'b1;
    cur[d*P +: P] = s;
  endtask

  task automatic set_raw(input int d, input logic [P-1:0] s);
    cur[d*P +: P] = s;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(cur, 1'b0);
  endtask

  initial begin
    int           hold_left [D];
    int           r, guard;
    logic [P-1:0] s;
    bus.In = '0;

    // Reset with random input, then d0 settles at LOW
    for (int i = 0; i < 2; i++) begin
      for (int d = 0; d < D; d++) cur[d*P +: P] = P'($urandom);
      step(cur, 1'b1);
    end
    cur = '0;
    set_pos(0, 0);         hold(6);
    // d0 HIGH then LOW: carry
    set_pos(0, P-1);       hold(5);
    set_pos(0, 0);         hold(5);
    // d1 LOW->HIGH borrow, then LOW->MID->HIGH without pulse
    set_pos(1, 0);         hold(5);
    set_pos(1, P-1);       hold(5);
    set_pos(1, 0);         hold(5);
    set_pos(1, 5);         hold(5);
    set_pos(1, P-1);       hold(5);
    // d2 short glitch, then zero-hot hold
    set_pos(2, P-1);       hold(5);
    set_pos(2, 0);         hold(2);
    set_pos(2, P-1);       hold(5);
    set_raw(2, '0);        hold(20);
    // d0 carry and d3 borrow in the same cycle
    set_pos(0, P-1); set_pos(3, 0);   hold(5);
    set_pos(0, 0);   set_pos(3, P-1); hold(5);
    // same pair again, with reset landing on the pulse edge
    set_pos(0, P-1); set_pos(3, 0);   hold(5);
    set_pos(0, 0);   set_pos(3, P-1); hold(3);
    step(cur, 1'b1);
    hold(5);
    // multi-hot on d1, then valid input, then reset
    set_raw(1, P'(10'b0000010001));   hold(3);
    set_pos(1, 3);                    hold(5);
    step(cur, 1'b1);
    hold(4);

    // Randomized segments per digit, with occasional reset
    for (int d = 0; d < D; d++) hold_left[d] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < D; d++) begin
        if (hold_left[d] == 0) begin
          r = $urandom_range(0, 99);
          if (r < 30)      set_pos(d, 0);
          else if (r < 60) set_pos(d, P-1);
          else if (r < 80) set_pos(d, $urandom_range(1, P-2));
          else if (r < 88) set_raw(d, '0);
          else begin
            s = '0;
            s[$urandom_range(0, P-1)] = 1'b1;
            s[$urandom_range(0, P-1)] = 1'b1;
            set_raw(d, s);
          end
          hold_left[d] = $urandom_range(1, F+5);
        end
        hold_left[d]--;
      end
      step(cur, ($urandom_range(0, 249) == 0));
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
